// File: rtl/nexys_starship_monster_bank_pkg.sv
// Shared types and helpers for the Nexys Starship monster bank.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package nexys_starship_pkg;

  typedef enum logic [2:0] {
    L_INIT  = 3'b001,
    L_EMPTY = 3'b010,
    L_FULL  = 3'b100
  } lane_state_t;

  typedef enum logic [1:0] {
    G_INIT = 2'd0,
    G_PLAY = 2'd1,
    G_OVER = 2'd2
  } game_state_t;

  // Timeout shrinks with level but never below the floor; the product is
  // formed 64 bits wide so a large level cannot wrap the subtraction.
  function automatic logic [31:0] eff_timeout(input logic [31:0] lvl,
                                              input logic [31:0] base,
                                              input logic [31:0] step,
                                              input logic [31:0] floor_t);
    logic [63:0] dec;
    dec = 64'(lvl) * 64'(step);
    if (dec >= 64'(base)) return floor_t;
    if ((base - dec[31:0]) > floor_t) return base - dec[31:0];
    return floor_t;
  endfunction

  // Warn threshold is timeout minus the warn window, clamped at zero.
  function automatic logic [31:0] warn_threshold(input logic [31:0] t,
                                                 input logic [31:0] w);
    return (t > w) ? (t - w) : 32'd0;
  endfunction

  function automatic logic [31:0] popcount(input logic [63:0] v);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < 64; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/nexys_starship_monster_bank_if.sv
// Game-controller side bundle of the monster bank: controls in, lane status out.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level or strobe.
interface nexys_starship_monster_bank_if #(
  parameter int N_LANES = 4,
  parameter int LVL_W   = 3,
  parameter int CNT_W   = 8
);
  localparam int AC_W = $clog2(N_LANES + 1);

  logic               tick;
  logic               play_flag;
  logic               gameover_ctrl;
  logic [LVL_W-1:0]   level;
  logic [N_LANES-1:0] lane_random;
  logic [N_LANES-1:0] lane_shield;
  logic [N_LANES-1:0] monster;
  logic [N_LANES-1:0] q_init;
  logic [N_LANES-1:0] q_empty;
  logic [N_LANES-1:0] q_full;
  logic [N_LANES-1:0] warn;
  logic [AC_W-1:0]    active_count;
  logic [CNT_W-1:0]   defeated_count;
  logic               gameover;
  logic [N_LANES-1:0] gameover_lane;

  modport master (
    output tick, play_flag, gameover_ctrl, level, lane_random, lane_shield,
    input  monster, q_init, q_empty, q_full, warn, active_count,
           defeated_count, gameover, gameover_lane
  );

  modport slave (
    input  tick, play_flag, gameover_ctrl, level, lane_random, lane_shield,
    output monster, q_init, q_empty, q_full, warn, active_count,
           defeated_count, gameover, gameover_lane
  );
endinterface

// File: rtl/nexys_starship_monster_bank_lane.sv
// One monster terminal: INIT/EMPTY/FULL machine with spawn delay, timeout timer and warn flag.
// Latency: state and warn registered, one Clk; expire_* are combinational from registered timer.
// Backpressure: none; spawns only when the bank grants, force_init overrides everything.
module nexys_starship_lane
  import nexys_starship_pkg::*;
#(
  parameter int TMR_W       = 8,
  parameter int SPAWN_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        force_init,
  input  logic        spawn_grant,
  input  logic        shield,
  input  logic [31:0] timeout,
  input  logic [31:0] warn_thr,
  output logic        armed,
  output logic        expire_ok,
  output logic        expire_fault,
  output logic        q_init,
  output logic        q_empty,
  output logic        q_full,
  output logic        warn
);
  localparam logic [TMR_W-1:0] TMR_MAX = '1;

  lane_state_t      state, nxt_state;
  logic [TMR_W-1:0] timer, nxt_timer;
  logic [TMR_W-1:0] delay, nxt_delay;
  logic             expire;

  assign expire       = (state == L_FULL) && (32'(timer) >= timeout);
  assign expire_ok    = expire && shield;
  assign expire_fault = expire && !shield;
  assign armed        = (state == L_EMPTY) && (32'(delay) >= 32'(SPAWN_DELAY));
  assign q_init       = state[0];
  assign q_empty      = state[1];
  assign q_full       = state[2];

  // Next-state: spawn wins over a same-cycle tick, so a fresh monster starts at timer 0.
  always_comb begin
    nxt_state = state;
    nxt_timer = timer;
    nxt_delay = delay;
    if (force_init) begin
      nxt_state = L_INIT;
      nxt_timer = '0;
      nxt_delay = '0;
    end else begin
      unique case (state)
        L_INIT: begin
          nxt_state = L_EMPTY;
          nxt_timer = '0;
          nxt_delay = '0;
        end
        L_EMPTY: begin
          if (spawn_grant) begin
            nxt_state = L_FULL;
            nxt_timer = '0;
            nxt_delay = '0;
          end else if (tick && delay != TMR_MAX) begin
            nxt_delay = delay + 1'b1;
          end
        end
        L_FULL: begin
          if (expire_ok) begin
            nxt_state = L_EMPTY;
            nxt_timer = '0;
            nxt_delay = '0;
          end else if (tick && timer != TMR_MAX) begin
            nxt_timer = timer + 1'b1;
          end
        end
        default: nxt_state = L_INIT;
      endcase
    end
  end

  // Register lane state; warn is derived from next values so it lines up with the timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= L_INIT;
      timer <= '0;
      delay <= '0;
      warn  <= 1'b0;
    end else begin
      state <= nxt_state;
      timer <= nxt_timer;
      delay <= nxt_delay;
      warn  <= (nxt_state == L_FULL) && (32'(nxt_timer) >= warn_thr);
    end
  end
endmodule

// File: rtl/nexys_starship_monster_bank.sv
// N-lane monster bank: global game FSM, lowest-index spawn arbiter with cap, defeat/gameover bookkeeping.
// Latency: every output registered, one Clk from cause to effect.
// Backpressure: spawn requests beyond the free-slot budget stay armed and retry next cycle.
module nexys_starship_monster_bank
  import nexys_starship_pkg::*;
#(
  parameter int N_LANES      = 4,
  parameter int TMR_W        = 8,
  parameter int BASE_TIMEOUT = 12,
  parameter int LEVEL_STEP   = 2,
  parameter int MIN_TIMEOUT  = 4,
  parameter int SPAWN_DELAY  = 1,
  parameter int MAX_ACTIVE   = 3,
  parameter int WARN_TICKS   = 3,
  parameter int LVL_W        = 3,
  parameter int CNT_W        = 8
) (
  input logic                           Clk,
  input logic                           Reset_n,
  nexys_starship_monster_bank_if.slave  bus
);
  localparam int               AC_W    = $clog2(N_LANES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  game_state_t        gstate;
  logic [LVL_W-1:0]   lvl;
  logic [31:0]        tmo, wthr;
  logic               enter_play, go_over, force_init;
  logic [N_LANES-1:0] armed, exp_ok, exp_fault, grant, next_full;
  logic [N_LANES-1:0] q_init, q_empty, q_full, warn;
  logic [AC_W-1:0]    active_count;
  logic [CNT_W-1:0]   defeated_count, dc_next;
  logic               gameover;
  logic [N_LANES-1:0] gameover_lane;
  logic [63:0]        dc_sum;

  assign lvl  = bus.level;
  assign tmo  = eff_timeout(32'(lvl), 32'(BASE_TIMEOUT), 32'(LEVEL_STEP), 32'(MIN_TIMEOUT));
  assign wthr = warn_threshold(tmo, 32'(WARN_TICKS));

  // Lanes run only while the game is (or is becoming) live; any other cycle pins them to INIT.
  assign enter_play = (gstate == G_INIT) && bus.play_flag;
  assign go_over    = (gstate == G_PLAY) && ((|exp_fault) || bus.gameover_ctrl);
  assign force_init = !(enter_play || ((gstate == G_PLAY) && !go_over));

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    nexys_starship_lane #(
      .TMR_W       (TMR_W),
      .SPAWN_DELAY (SPAWN_DELAY)
    ) u_lane (
      .clk          (Clk),
      .rst_n        (Reset_n),
      .tick         (bus.tick),
      .force_init   (force_init),
      .spawn_grant  (grant[i]),
      .shield       (bus.lane_shield[i]),
      .timeout      (tmo),
      .warn_thr     (wthr),
      .armed        (armed[i]),
      .expire_ok    (exp_ok[i]),
      .expire_fault (exp_fault[i]),
      .q_init       (q_init[i]),
      .q_empty      (q_empty[i]),
      .q_full       (q_full[i]),
      .warn         (warn[i])
    );
  end

  // Arbiter: budget excludes lanes leaving FULL this cycle, so freed slots reopen next Clk.
  always_comb begin
    logic [31:0] leaving, used, slots;
    leaving = popcount(64'(exp_ok | exp_fault));
    slots   = 32'd0;
    if (32'(MAX_ACTIVE) > 32'(active_count) + leaving)
      slots = 32'(MAX_ACTIVE) - 32'(active_count) - leaving;
    used  = 32'd0;
    grant = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (!force_init && armed[i] && bus.lane_random[i] && (used < slots)) begin
        grant[i] = 1'b1;
        used     = used + 32'd1;
      end
    end
  end

  assign next_full = force_init ? '0 : ((q_full & ~exp_ok) | grant);
  assign dc_sum    = 64'(defeated_count) + 64'(popcount(64'(exp_ok)));
  assign dc_next   = (dc_sum > 64'(CNT_MAX)) ? CNT_MAX : CNT_W'(dc_sum);

  // Global game FSM with its registered bookkeeping outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gstate         <= G_INIT;
      gameover       <= 1'b0;
      gameover_lane  <= '0;
      defeated_count <= '0;
      active_count   <= '0;
    end else begin
      active_count <= AC_W'(popcount(64'(next_full)));
      unique case (gstate)
        G_INIT: begin
          if (bus.play_flag) begin
            gstate         <= G_PLAY;
            defeated_count <= '0;
            gameover_lane  <= '0;
          end
        end
        G_PLAY: begin
          defeated_count <= dc_next;
          gameover_lane  <= gameover_lane | exp_fault;
          if (go_over) begin
            gstate   <= G_OVER;
            gameover <= 1'b1;
          end
        end
        G_OVER: begin
          if (!bus.play_flag) begin
            gstate   <= G_INIT;
            gameover <= 1'b0;
          end
        end
        default: begin
          gstate   <= G_INIT;
          gameover <= 1'b0;
        end
      endcase
    end
  end

  assign bus.monster        = q_full;
  assign bus.q_init         = q_init;
  assign bus.q_empty        = q_empty;
  assign bus.q_full         = q_full;
  assign bus.warn           = warn;
  assign bus.active_count   = active_count;
  assign bus.defeated_count = defeated_count;
  assign bus.gameover       = gameover;
  assign bus.gameover_lane  = gameover_lane;
endmodule
